// File: rtl/uart_telemetry_hub.sv
// UART telemetry/command hub: periodic binary frame of NUM_CH sensor channels on tx,
// ASCII "L<idx><val>\n" LED commands on rx. Checksum byte enabled by UART_TELEM_CKSUM_EN.
module uart_telemetry_hub #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int NUM_CH    = 2,
  parameter int CH_W      = 16,
  parameter int NUM_LED   = 2,
  parameter int TX_PERIOD = 100_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  input  logic                     rx,
  output logic                     tx,
  output logic [NUM_LED-1:0]       led,
  output logic                     frame_busy,
  output logic                     cmd_err
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int BPC      = (CH_W + 7) / 8;
  localparam int NB       = NUM_CH * BPC;
  localparam int CW       = $clog2(BAUD_DIV + 1);
  localparam int PW       = $clog2(TX_PERIOD + 1);
  localparam int IW       = $clog2(NB + 1);
  localparam int HALF_M1  = (BAUD_DIV / 2 > 0) ? BAUD_DIV / 2 - 1 : 0;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {F_IDLE, F_SYNC, F_PAYLOAD, F_CKSUM} f_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} t_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
  typedef enum logic [1:0] {P_IDLE, P_IDX, P_VAL, P_EOL} p_state_t;

  // ---------------- period counter ----------------
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic          frame_req;

  assign frame_req = (per_cnt_q == PW'(TX_PERIOD - 1));
  assign per_cnt_d = frame_req ? '0 : per_cnt_q + 1'b1;

  // ---------------- payload byte table from the shadow copy ----------------
  logic [NUM_CH*CH_W-1:0] shadow_q, shadow_d;
  logic [7:0]             pay_byte [NB];

  generate
    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
      logic [BPC*8-1:0] padded;
      assign padded = (BPC*8)'(shadow_q[gc*CH_W +: CH_W]);
      for (genvar gb = 0; gb < BPC; gb++) begin : g_byte
        assign pay_byte[gc*BPC + gb] = padded[(BPC-1-gb)*8 +: 8];
      end
    end
  endgenerate

  // ---------------- frame sequencer ----------------
  f_state_t      f_state_q, f_state_d;
  logic [IW-1:0] byte_idx_q, byte_idx_d, sel_idx;
  logic [7:0]    cksum_q, cksum_d, sel_byte, load_byte;
  logic          load, tx_byte_done, frame_busy_q, frame_busy_d;

  always_comb begin
    f_state_d  = f_state_q;
    byte_idx_d = byte_idx_q;
    cksum_d    = cksum_q;
    shadow_d   = shadow_q;
    load       = 1'b0;
    load_byte  = SYNC_BYTE;
    // Next payload byte: index 0 after the sync byte, otherwise the one after the current.
    sel_idx    = (f_state_q == F_PAYLOAD) ? byte_idx_q + 1'b1 : '0;
    sel_byte   = '0;
    for (int i = 0; i < NB; i++) begin
      if (sel_idx == IW'(i)) sel_byte = pay_byte[i];
    end
    case (f_state_q)
      F_IDLE: if (frame_req) begin
        shadow_d   = ch_data;
        cksum_d    = '0;
        byte_idx_d = '0;
        load       = 1'b1;
        load_byte  = SYNC_BYTE;
        f_state_d  = F_SYNC;
      end
      F_SYNC: if (tx_byte_done) begin
        load       = 1'b1;
        load_byte  = sel_byte;
        cksum_d    = cksum_q + sel_byte;
        byte_idx_d = '0;
        f_state_d  = F_PAYLOAD;
      end
      F_PAYLOAD: if (tx_byte_done) begin
        if (byte_idx_q == IW'(NB - 1)) begin
`ifdef UART_TELEM_CKSUM_EN
          load      = 1'b1;
          load_byte = cksum_q;
          f_state_d = F_CKSUM;
`else
          f_state_d = F_IDLE;
`endif
        end else begin
          load       = 1'b1;
          load_byte  = sel_byte;
          cksum_d    = cksum_q + sel_byte;
          byte_idx_d = byte_idx_q + 1'b1;
        end
      end
      F_CKSUM: if (tx_byte_done) f_state_d = F_IDLE;
      default: f_state_d = F_IDLE;
    endcase
    frame_busy_d = (f_state_d != F_IDLE);
  end

  // ---------------- byte serialiser ----------------
  t_state_t      tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;

  assign tx_byte_done = (tx_state_q == T_STOP) && (tx_cnt_q == CW'(BAUD_DIV - 1));

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      T_IDLE: begin
        tx_d = 1'b1;
        if (load) begin
          tx_state_d = T_START;
          tx_cnt_d   = '0;
          tx_shift_d = load_byte;
          tx_d       = 1'b0;
        end
      end
      T_START: if (tx_cnt_q == CW'(BAUD_DIV - 1)) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = T_DATA;
        tx_d       = tx_shift_q[0];
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      T_DATA: if (tx_cnt_q == CW'(BAUD_DIV - 1)) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = T_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      T_STOP: if (tx_byte_done) begin
        tx_cnt_d = '0;
        // Chain straight into the next start bit so bytes are back-to-back.
        if (load) begin
          tx_state_d = T_START;
          tx_shift_d = load_byte;
          tx_d       = 1'b0;
        end else tx_state_d = T_IDLE;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      default: tx_state_d = T_IDLE;
    endcase
  end

  // ---------------- RX front end ----------------
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  r_state_t      rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid, rx_ferr;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      R_IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_state_d = R_START;
        rx_cnt_d   = '0;
      end
      R_START: if (rx_cnt_q == CW'(HALF_M1)) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      R_DATA: if (rx_cnt_q == CW'(BAUD_DIV - 1)) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
        else                  rx_bit_d   = rx_bit_q + 1'b1;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      R_STOP: if (rx_cnt_q == CW'(BAUD_DIV - 1)) begin
        rx_cnt_d   = '0;
        rx_state_d = R_IDLE;
        rx_valid   = rx_sync_q;
        rx_ferr    = !rx_sync_q;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: rx_state_d = R_IDLE;
    endcase
  end

  // ---------------- command parser ----------------
  p_state_t           p_state_q, p_state_d;
  logic [3:0]         idx_q, idx_d;
  logic               val_q, val_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic               cmd_err_q, cmd_err_d;

  always_comb begin
    p_state_d = p_state_q;
    idx_d     = idx_q;
    val_d     = val_q;
    led_d     = led_q;
    cmd_err_d = 1'b0;
    if (rx_ferr) begin
      p_state_d = P_IDLE;
      cmd_err_d = 1'b1;
    end else if (rx_valid) begin
      // Any mismatch outside P_IDLE (including a stray 'L') aborts the command.
      p_state_d = P_IDLE;
      case (p_state_q)
        P_IDLE: if (rx_shift_q == 8'h4C) p_state_d = P_IDX;
        P_IDX: if (rx_shift_q >= 8'h30 && rx_shift_q < 8'(8'h30 + NUM_LED)) begin
          idx_d     = 4'(rx_shift_q - 8'h30);
          p_state_d = P_VAL;
        end else cmd_err_d = 1'b1;
        P_VAL: if (rx_shift_q == 8'h30 || rx_shift_q == 8'h31) begin
          val_d     = rx_shift_q[0];
          p_state_d = P_EOL;
        end else cmd_err_d = 1'b1;
        P_EOL: if (rx_shift_q == 8'h0A) begin
          for (int i = 0; i < NUM_LED; i++) begin
            if (idx_q == 4'(i)) led_d[i] = val_q;
          end
        end else cmd_err_d = 1'b1;
        default: p_state_d = P_IDLE;
      endcase
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q    <= '0;
      shadow_q     <= '0;
      f_state_q    <= F_IDLE;
      byte_idx_q   <= '0;
      cksum_q      <= '0;
      frame_busy_q <= 1'b0;
      tx_state_q   <= T_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_q         <= 1'b1;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= R_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      p_state_q    <= P_IDLE;
      idx_q        <= '0;
      val_q        <= 1'b0;
      led_q        <= '0;
      cmd_err_q    <= 1'b0;
    end else begin
      per_cnt_q    <= per_cnt_d;
      shadow_q     <= shadow_d;
      f_state_q    <= f_state_d;
      byte_idx_q   <= byte_idx_d;
      cksum_q      <= cksum_d;
      frame_busy_q <= frame_busy_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_q         <= tx_d;
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      p_state_q    <= p_state_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      led_q        <= led_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign tx         = tx_q;
  assign led        = led_q;
  assign frame_busy = frame_busy_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_uart_telemetry_hub.sv
// Bench for uart_telemetry_hub: per-cycle tx/frame_busy model, tx byte decoder with
// literal frame expectations, and directed LED command sequences on rx.
module tb_uart_telemetry_hub;

  localparam int CLK_HZ  = 160;
  localparam int BAUD    = 10;
  localparam int DIV     = CLK_HZ / BAUD;
  localparam int NUM_CH  = 2;
  localparam int CH_W    = 16;
  localparam int BPC     = 2;
  localparam int NUM_LED = 2;
  localparam int P       = 1500;
`ifdef UART_TELEM_CKSUM_EN
  localparam int NBYTES  = 6;
`else
  localparam int NBYTES  = 5;
`endif
  localparam int FLEN    = NBYTES * 10 * DIV;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_CH*CH_W-1:0] ch_data;
  logic                   rx = 1'b1;
  logic                   tx;
  logic [NUM_LED-1:0]     led;
  logic                   frame_busy;
  logic                   cmd_err;

  uart_telemetry_hub #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_CH(NUM_CH), .CH_W(CH_W),
    .NUM_LED(NUM_LED), .TX_PERIOD(P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .rx(rx),
    .tx(tx), .led(led), .frame_busy(frame_busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- frame model: bytes built from the snapshot at each frame start ----------------
  int exp_bytes [NBYTES];

  function automatic void build_frame(input logic [31:0] d);
    int n;
    int sum;
    int v;
    n = 1;
    sum = 0;
    exp_bytes[0] = 'hA5;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      v = int'((d >> (ch * CH_W)) & 32'hFFFF);
      for (int b = BPC - 1; b >= 0; b--) begin
        exp_bytes[n] = (v >> (8 * b)) & 255;
        sum += exp_bytes[n];
        n++;
      end
    end
`ifdef UART_TELEM_CKSUM_EN
    exp_bytes[n] = sum % 256;
`endif
  endfunction

  always @(negedge clk) begin
    int k, o, bi, bp, etx, ebusy;
    if (rst_n && mon_en) begin
      if (cyc > 0 && cyc % P == 0) build_frame(ch_data);
      k = cyc / P;
      o = cyc % P;
      if (k >= 1 && o < FLEN) begin
        bi = o / (10 * DIV);
        bp = (o % (10 * DIV)) / DIV;
        if (bp == 0)      etx = 0;
        else if (bp == 9) etx = 1;
        else              etx = (exp_bytes[bi] >> (bp - 1)) & 1;
        ebusy = 1;
      end else begin
        etx = 1;
        ebusy = 0;
      end
      check("tx", 32'(tx), 32'(etx));
      check("frame_busy", 32'(frame_busy), 32'(ebusy));
    end
  end

  // ---------------- tx byte decoder, busy and cmd_err counters ----------------
  logic [7:0] dec_q [$];
  int         first_fall = -1;
  bit         in_byte = 1'b0;
  int         t0 = 0;
  logic [7:0] sh = '0;
  int         busy_cnt = 0;
  int         err_cnt = 0;

  always @(negedge clk) begin
    int o;
    if (!rst_n) begin
      in_byte    = 1'b0;
      first_fall = -1;
    end else begin
      if (frame_busy === 1'b1) busy_cnt++;
      if (cmd_err === 1'b1) err_cnt++;
      if (!in_byte) begin
        if (tx === 1'b0) begin
          in_byte = 1'b1;
          t0 = cyc;
          if (first_fall < 0) first_fall = cyc;
        end
      end else begin
        o = cyc - t0;
        if (o >= DIV + DIV / 2 && o < 9 * DIV && (o - DIV / 2) % DIV == 0)
          sh = {tx, sh[7:1]};
        if (o == 9 * DIV + DIV / 2) begin
          check("tx_stop_bit", 32'(tx), 32'd1);
          dec_q.push_back(sh);
          in_byte = 1'b0;
        end
      end
    end
  end

  // ---------------- rx stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  // ---------------- literal frame expectations ----------------
`ifdef UART_TELEM_CKSUM_EN
  logic [7:0] lit_f1 [NBYTES] = '{8'hA5, 8'h00, 8'h4B, 8'h00, 8'h62, 8'hAD};
  logic [7:0] lit_f2 [NBYTES] = '{8'hA5, 8'h00, 8'h7D, 8'h00, 8'h50, 8'hCD};
`else
  logic [7:0] lit_f1 [NBYTES] = '{8'hA5, 8'h00, 8'h4B, 8'h00, 8'h62};
  logic [7:0] lit_f2 [NBYTES] = '{8'hA5, 8'h00, 8'h7D, 8'h00, 8'h50};
`endif

  initial begin
    logic [7:0] exp_dec [$];
    int e0;
    int n;

    ch_data = {16'd98, 16'd75};
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(frame_busy), 32'd0);
    check("reset_led", 32'(led), 32'd0);
    check("reset_cmd_err", 32'(cmd_err), 32'd0);

    rst_n  = 1'b1;
    mon_en = 1'b1;
    fork
      begin
        repeat (1800) @(negedge clk);
        ch_data = {16'd80, 16'd125};
      end
      begin
        repeat (1600) @(negedge clk);
        check("first_start_cycle", 32'(first_fall), 32'(P));
      end
      begin
        repeat (2900) @(negedge clk);
        check("busy_length_frame1", 32'(busy_cnt), 32'(FLEN));
      end
      begin
        repeat (40) @(negedge clk);
        e0 = err_cnt;
        send_str("L11");
        check("led_before_eol", 32'(led), 32'd0);
        send_byte(8'h0A, 1'b1);
        check("led_after_L11", 32'(led), 32'b10);
        send_str("L00\n");
        check("led_after_L00", 32'(led), 32'b10);
        check("err_none_valid", 32'(err_cnt - e0), 32'd0);
        e0 = err_cnt;
        send_str("L2");
        check("err_bad_idx", 32'(err_cnt - e0), 32'd1);
        send_str("1\n");
        check("err_after_bad_idx", 32'(err_cnt - e0), 32'd1);
        check("led_after_L21", 32'(led), 32'b10);
        e0 = err_cnt;
        send_str("Lx");
        check("err_bad_val", 32'(err_cnt - e0), 32'd1);
        e0 = err_cnt;
        send_byte(8'h4C, 1'b1);
        send_byte(8'h31, 1'b0);
        check("err_framing", 32'(err_cnt - e0), 32'd1);
        e0 = err_cnt;
        send_str("L01\n");
        check("led_after_L01", 32'(led), 32'b11);
        check("err_none_L01", 32'(err_cnt - e0), 32'd0);
      end
    join

    while (cyc < 4800) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset_tx", 32'(tx), 32'd1);
    check("midframe_reset_busy", 32'(frame_busy), 32'd0);
    check("midframe_reset_led", 32'(led), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1600) @(negedge clk);
    check("restart_start_cycle", 32'(first_fall), 32'(P));
    repeat (1000) @(negedge clk);

    for (int i = 0; i < NBYTES; i++) exp_dec.push_back(lit_f1[i]);
    for (int i = 0; i < NBYTES; i++) exp_dec.push_back(lit_f2[i]);
    exp_dec.push_back(8'hA5);
    for (int i = 0; i < NBYTES; i++) exp_dec.push_back(lit_f2[i]);
    check("decoded_byte_count", 32'(dec_q.size()), 32'(exp_dec.size()));
    n = (dec_q.size() < exp_dec.size()) ? dec_q.size() : exp_dec.size();
    for (int i = 0; i < n; i++)
      check($sformatf("decoded_byte_%0d", i), 32'(dec_q[i]), 32'(exp_dec[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_telemetry_hub.md
# uart_telemetry_hub

Parametrised UART telemetry/command block that replaces the fixed two-sensor UART top. It periodically snapshots `NUM_CH` sensor channels of `CH_W` bits each and transmits them as one binary frame on `tx`. In parallel it parses ASCII LED commands on `rx` and drives `NUM_LED` LED outputs. It sits between the sensor-processing datapath and the board UART pins.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `BAUD`, 9600, line rate; `BAUD_DIV = CLK_HZ/BAUD`, truncated (10416 at defaults).
- `NUM_CH`, 2, number of telemetry channels (1..16).
- `CH_W`, 16, bits per channel (1..32); `BPC = (CH_W+7)/8` bytes per channel.
- `NUM_LED`, 2, number of LED outputs (1..10).
- `TX_PERIOD`, 100_000_000, clock cycles between frame starts.
- `clk` in 1: system clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ch_data` in `NUM_CH*CH_W`: channel *k* occupies bits `[k*CH_W +: CH_W]`.
- `rx` in 1: UART receive line, asynchronous to `clk`, idle high.
- `tx` out 1: UART transmit line, idle high.
- `led` out `NUM_LED`: LED states.
- `frame_busy` out 1: high while a frame is being transmitted.
- `cmd_err` out 1: one-cycle pulse on a rejected command byte or an RX framing error.

## Operation
- **Reset values:** `tx`=1, `led`=0, `frame_busy`=0, `cmd_err`=0. The period counter, both FSMs and the parser all return to idle.
- **UART format:** 8N1, LSB first. One bit lasts `BAUD_DIV` cycles.
- **Period counter:** counts 0..`TX_PERIOD-1`. On the wrap it requests a frame.
  - If a frame is still busy at the wrap, the request is dropped (no queuing). The counter keeps running.
- **Frame layout:** `0xA5`, then channels 0..`NUM_CH-1`. Each channel is sent as `BPC` bytes, MSB byte first, with unused upper bits zero-padded. An optional checksum byte follows (see Configuration).
- **Data capture:** all of `ch_data` is captured into a shadow register on the cycle the frame starts. Changes to `ch_data` mid-frame do not affect the frame in flight.
- **Frame sequencer states:** `F_IDLE`, `F_SYNC`, `F_PAYLOAD` (byte index 0..`NUM_CH*BPC-1`), `F_CKSUM`, then back to `F_IDLE`.
- **Byte serialiser states:** `T_IDLE`, `T_START`, `T_DATA` (bit 0..7), `T_STOP`. Bytes are sent back-to-back with no idle gap between them.
- **RX front end:**
  - `rx` passes through a 2-flop synchroniser before any use.
  - A falling edge while idle starts a byte. The line is re-checked at `BAUD_DIV/2`; if it is high, the start is false and the receiver returns to idle silently.
  - Data bits are sampled at mid-bit. The stop bit must read 1; if it reads 0, the byte is discarded, `cmd_err` pulses, and the parser resets.
- **Command parser states:** `P_IDLE`, `P_IDX`, `P_VAL`, `P_EOL`.
  - `P_IDLE`: waits for `'L'` (0x4C). Any other byte is ignored silently.
  - `P_IDX`: accepts `'0'`..`'0'+NUM_LED-1`.
  - `P_VAL`: accepts `'0'` or `'1'`.
  - `P_EOL`: accepts `'\n'` (0x0A).
  - Any unexpected byte in `P_IDX`, `P_VAL` or `P_EOL` pulses `cmd_err` and returns the parser to `P_IDLE`. An unexpected `'L'` also returns to `P_IDLE`; it is not treated as a new command start.
  - On a valid `'\n'`, `led[idx]` is set to the value; all other LEDs keep their state.
- **Independence:** the TX and RX paths run fully in parallel. A command may arrive during a frame.
- **Reset mid-frame:** `tx` goes to 1 immediately (asynchronous). The partial frame is abandoned, never resumed.

## Timing
- **First frame:** the first start bit begins `TX_PERIOD` cycles after `rst_n` deasserts. After that, frames start every `TX_PERIOD` cycles.
- **frame_busy:** rises in the same cycle the start bit of `0xA5` is driven. It falls in the cycle after the last stop bit completes.
- **Frame length:** `(1 + NUM_CH*BPC + C) * 10 * BAUD_DIV` cycles, where C=1 if the checksum is enabled, else 0. The integrator must choose `TX_PERIOD` larger than this.
- **LED update latency:** `led` updates exactly 1 cycle after the mid-bit sample of the `'\n'` stop bit.
- **cmd_err timing:** pulses in the same cycle a framing error or bad byte is detected.

## Configuration
- `UART_TELEM_CKSUM_EN` defined: a checksum byte is appended after the payload. The checksum is the sum of all payload bytes modulo 256; the sync byte is excluded.
- `UART_TELEM_CKSUM_EN` undefined: no checksum byte, and the frame is one byte shorter.

## Test plan
All scenarios use default parameters, `TX_PERIOD`=1_000_000 and checksum enabled.

- **Basic frame:** `ch_data`={16'd98, 16'd75} (channel 0 = 75) → bytes `A5 00 4B 00 62 AD` on `tx`. The first start bit appears at cycle 1_000_000 after reset release. `frame_busy` is high for 6×10×10416 cycles.
- **Mid-frame data change:** change `ch_data` to {80, 125} during the first frame → the first frame is unchanged. The next frame is `A5 00 7D 00 50 CD`.
- **Valid command:** send `"L11\n"` on `rx` → `led`=2'b10 one cycle after the `'\n'` stop-bit sample. Then send `"L00\n"` → `led` stays 2'b10.
- **Rejected commands:**
  - `"L21\n"` → `cmd_err` pulses on `'2'` and `led` is unchanged.
  - `"Lx"` → `cmd_err` pulses.
  - A byte with stop bit=0 → `cmd_err` pulses and the parser returns to idle. A following valid `"L01\n"` gives `led[0]`=1.
- **Reset mid-frame:** assert `rst_n`=0 in the middle of the payload → `tx`=1 and `frame_busy`=0 immediately, `led`=0. After release, the next frame starts `TX_PERIOD` cycles later.
- **Checksum disabled:** build without `UART_TELEM_CKSUM_EN` using the scenario 1 data → frame is `A5 00 4B 00 62`, and `frame_busy` is high for 5×10×10416 cycles.
